usb_bus_ctrl: RTL and testbench
===============================

// Module: usb_bus_ctrl
// PURPOSE
//  Sequences the shared 32-bit FT601-style sync-FIFO bus between the USB RX path and the TX path.
//  Pops host words into the internal RX FIFO and pushes TX FIFO words to the host.
//  Owns bus direction, turnaround and the active-low strobes. Arbitrates RX/TX round-robin with a burst cap.
//  Sits between the lycan top-level usb_* pins and the internal packet FIFOs.
// PARAMETERS
//  WIDTH      32  bus/data width (fixed to 32 in lycan_globals; BE width = WIDTH/8)
//  MAX_BURST  16  max words per grant before yielding if the other side is pending (>=1)
// PORTS
//  clk           in     1   system clock (USB bus clock domain)
//  rst           in     1   asynchronous, active-high reset
//  usb_data      inout  32  FT601 data bus
//  usb_be        inout  4   FT601 byte enables
//  usb_rx_empty  in     1   1 = no host data available
//  usb_tx_full   in     1   1 = host TX buffer full
//  usb_rden_l    out    1   read strobe, active low
//  usb_wren_l    out    1   write strobe, active low
//  usb_outen_l   out    1   FT601 drives bus when low
//  rx_afull      in     1   RX FIFO cannot take 2 more words
//  rx_wren       out    1   RX FIFO push
//  rx_wdata      out    32  RX FIFO push data
//  tx_empty      in     1   TX FIFO (first-word-fall-through) empty
//  tx_rdata      in     32  TX FIFO head word
//  tx_rden       out    1   TX FIFO pop
// BEHAVIOUR
//  Reset: usb_rden_l=usb_wren_l=usb_outen_l=1, rx_wren=0, rx_wdata=0, tx_rden=0, bus released (Z), state IDLE, last_grant=TX.
//  Reset mid-burst: same; any partially captured word is dropped; no strobe glitches low.
//  rd_req = !usb_rx_empty & !rx_afull; wr_req = !tx_empty & !usb_tx_full.
//  FSM states: IDLE, RD_TA, RD_BURST, WR_BURST, WR_TA.
//   IDLE: rd_req & wr_req -> grant the side opposite last_grant; else the requesting side. RD -> RD_TA; WR -> WR_BURST.
//   RD_TA (1 cycle): usb_outen_l=0, rden_l=1 (bus turnaround) -> RD_BURST.
//   RD_BURST: outen_l=0; rden_l=0 while rd_req; capture word each cycle with !rden_l & !usb_rx_empty.
//     Exit on !rd_req, or burst count==MAX_BURST with wr_req -> WR_TA; else (count cap, no wr_req) continue.
//   WR_TA (1 cycle): all strobes high, bus Z -> IDLE (outen deassert to FPGA drive gap).
//   WR_BURST: FPGA drives usb_data=tx_rdata, usb_be=4'hF; wren_l=0 and tx_rden=1 combinationally while wr_req.
//     Exit on !wr_req, or count==MAX_BURST with rd_req -> IDLE (one idle cycle = turnaround before RD_TA).
//  RX latency: rx_wren/rx_wdata registered, 1 cycle after the capture edge; rx_afull covers that in-flight word.
//  usb_data/usb_be are driven only in WR_BURST; never driven while usb_outen_l=0 (no contention, asserted).
//  Burst counter: WIDTH $clog2(MAX_BURST+1), clears on every grant, saturates at MAX_BURST.
//  Simultaneous: rx_empty rising same cycle as rden_l low -> that word not captured; tx_full rising -> wren_l/tx_rden drop same cycle.
// CONFIGURATION
//  USB_BUS_CTRL_STATS_EN defined: adds outputs stat_rx_words[31:0], stat_tx_words[31:0], stat_turnarounds[15:0]
//   (wrap on overflow, clear on rst, count rx_wren, tx_rden, entries to RD_TA/WR_TA).
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  lycan_globals: typedef enum logic[2:0] usb_bus_state_t {IDLE,RD_TA,RD_BURST,WR_BURST,WR_TA};
//   localparam USB_BE_W = WIDTH/8; typedef enum logic {GRANT_RX,GRANT_TX} usb_grant_t.
//  Sub-module usb_bus_arbiter: round-robin grant + burst counter/yield decision; FSM and tristates stay in top.
// TESTING (mock FT601 FIFO model with outen/be tristate, configurable preload and empty delay)
//  1 RX only: 8 words preloaded, TX empty -> RD_TA 1 cycle, then 8 rx_wren pulses, data in order, no WR state.
//  2 TX only: 5 words in TX FIFO, rx_empty=1 -> 5 cycles wren_l=0, be=F, data matches, tx_rden x5.
//  3 Contention, MAX_BURST=4: 10 RX + 10 TX pending -> alternating 4-word bursts, TA cycles between, totals 10/10.
//  4 Back-pressure: rx_afull high after 3 words -> rden_l high next cycle, no lost/duplicated word on resume.
//  5 tx_full toggles mid-burst -> wren_l tracks combinationally, every TX word sent exactly once.
//  6 rst asserted mid-RD_BURST -> strobes high and bus Z same cycle; clean IDLE after release; stats=0 if STATS_EN.

Source files
------------

// File: rtl/usb_bus_ctrl_pkg.sv
// Shared types and the round-robin pick rule for the FT601-style USB bus controller.
package usb_bus_ctrl_pkg;

  localparam int USB_WIDTH = 32;
  localparam int USB_BE_W  = USB_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_TA,
    RD_BURST,
    WR_BURST,
    WR_TA
  } usb_bus_state_t;

  typedef enum logic {
    GRANT_RX,
    GRANT_TX
  } usb_grant_t;

  // When both sides want the bus, the side that did not win last time goes next.
  function automatic usb_grant_t rr_pick(input usb_grant_t last,
                                         input logic       rd_req,
                                         input logic       wr_req);
    if (rd_req && wr_req)
      return (last == GRANT_TX) ? GRANT_RX : GRANT_TX;
    return rd_req ? GRANT_RX : GRANT_TX;
  endfunction

endpackage

// File: rtl/usb_bus_ctrl_arbiter.sv
// Round-robin RX/TX grant plus the per-grant burst counter and the yield decision.
module usb_bus_arbiter
  import usb_bus_ctrl_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic rd_req,
  input  logic wr_req,
  input  logic in_rx,
  input  logic strobe,
  output logic grant_rd,
  output logic grant_wr,
  output logic yield
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  usb_grant_t       last_grant;
  usb_grant_t       pick;
  logic             grant;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Yield looks at the count including this cycle's strobe, so a burst stops after exactly MAX_BURST words.
  always_comb begin
    pick     = rr_pick(last_grant, rd_req, wr_req);
    grant    = idle && (rd_req || wr_req);
    grant_rd = grant && (pick == GRANT_RX);
    grant_wr = grant && (pick == GRANT_TX);
    cnt_inc  = (strobe && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;
    yield    = (cnt_inc == CNT_MAX) && (in_rx ? wr_req : rd_req);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_TX;
      cnt        <= '0;
    end else if (grant) begin
      last_grant <= pick;
      cnt        <= '0;
    end else begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/usb_bus_ctrl.sv
// FT601 sync-FIFO bus sequencer: RX pops into the packet FIFO, TX pushes to the host.
// Optional statistics outputs are enabled with USB_BUS_CTRL_STATS_EN.
module usb_bus_ctrl
  import usb_bus_ctrl_pkg::*;
#(
  parameter int WIDTH     = USB_WIDTH,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               rst,
  inout  wire  [WIDTH-1:0]   usb_data,
  inout  wire  [WIDTH/8-1:0] usb_be,
  input  logic               usb_rx_empty,
  input  logic               usb_tx_full,
  output logic               usb_rden_l,
  output logic               usb_wren_l,
  output logic               usb_outen_l,
  input  logic               rx_afull,
  output logic               rx_wren,
  output logic [WIDTH-1:0]   rx_wdata,
  input  logic               tx_empty,
  input  logic [WIDTH-1:0]   tx_rdata,
  output logic               tx_rden
`ifdef USB_BUS_CTRL_STATS_EN
  ,
  output logic [31:0]        stat_rx_words,
  output logic [31:0]        stat_tx_words,
  output logic [15:0]        stat_turnarounds
`endif
);

  usb_bus_state_t state;
  logic           rd_req;
  logic           wr_req;
  logic           grant_rd;
  logic           grant_wr;
  logic           yield;
  logic           strobe;
  logic           drive;
  logic           capture;
  logic           rd_exit;

  assign rd_req  = !usb_rx_empty && !rx_afull;
  assign wr_req  = !tx_empty && !usb_tx_full;
  assign drive   = (state == WR_BURST);
  assign capture = !usb_rden_l && !usb_rx_empty;
  assign rd_exit = (state == RD_BURST) && (!rd_req || yield);

  // Write strobe and FIFO pop follow tx_full/tx_empty in the same cycle.
  assign tx_rden    = drive && wr_req;
  assign usb_wren_l = !tx_rden;
  assign strobe     = ((state == RD_BURST) && !usb_rden_l) || tx_rden;

  assign usb_data = drive ? tx_rdata : {WIDTH{1'bz}};
  assign usb_be   = drive ? {(WIDTH/8){1'b1}} : {(WIDTH/8){1'bz}};

  usb_bus_arbiter #(
    .MAX_BURST(MAX_BURST)
  ) u_arbiter (
    .clk     (clk),
    .rst     (rst),
    .idle    (state == IDLE),
    .rd_req  (rd_req),
    .wr_req  (wr_req),
    .in_rx   (state == RD_BURST),
    .strobe  (strobe),
    .grant_rd(grant_rd),
    .grant_wr(grant_wr),
    .yield   (yield)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      usb_rden_l  <= 1'b1;
      usb_outen_l <= 1'b1;
      rx_wren     <= 1'b0;
      rx_wdata    <= '0;
    end else begin
      rx_wren <= capture;
      if (capture)
        rx_wdata <= usb_data;
      case (state)
        IDLE: begin
          if (grant_rd) begin
            state       <= RD_TA;
            usb_outen_l <= 1'b0;
          end else if (grant_wr) begin
            state <= WR_BURST;
          end
        end
        RD_TA: begin
          state      <= RD_BURST;
          usb_rden_l <= !rd_req;
        end
        RD_BURST: begin
          // The strobe issued in the last cycle still lands; rx_afull leaves room for it.
          if (rd_exit) begin
            state       <= WR_TA;
            usb_rden_l  <= 1'b1;
            usb_outen_l <= 1'b1;
          end else begin
            usb_rden_l <= 1'b0;
          end
        end
        WR_BURST: begin
          if (!wr_req || yield)
            state <= IDLE;
        end
        WR_TA: state <= IDLE;
        default: begin
          state       <= IDLE;
          usb_rden_l  <= 1'b1;
          usb_outen_l <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(drive && !usb_outen_l));
  end

`ifdef USB_BUS_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rx_words    <= '0;
      stat_tx_words    <= '0;
      stat_turnarounds <= '0;
    end else begin
      stat_rx_words <= stat_rx_words + 32'(rx_wren);
      stat_tx_words <= stat_tx_words + 32'(tx_rden);
      if (((state == IDLE) && grant_rd) || rd_exit)
        stat_turnarounds <= stat_turnarounds + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_bus_ctrl.sv
// Bench for usb_bus_ctrl: mock FT601 host plus RX/TX FIFO queues, scenario table and corner sequences.
module tb_usb_bus_ctrl;

  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  wire  [31:0] usb_data;
  wire  [3:0]  usb_be;
  logic        usb_rx_empty, usb_tx_full;
  logic        usb_rden_l, usb_wren_l, usb_outen_l;
  logic        rx_afull, rx_wren, tx_empty, tx_rden;
  logic [31:0] rx_wdata, tx_rdata, host_data;
`ifdef USB_BUS_CTRL_STATS_EN
  logic [31:0] stat_rx_words, stat_tx_words;
  logic [15:0] stat_turnarounds;
`endif

  always #5 clk = ~clk;

  // Host drives the bus only while it is told to output.
  assign usb_data = usb_outen_l ? {32{1'bz}} : host_data;
  assign usb_be   = usb_outen_l ? {4{1'bz}} : 4'hF;

  usb_bus_ctrl #(.WIDTH(32), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .usb_data(usb_data), .usb_be(usb_be),
    .usb_rx_empty(usb_rx_empty), .usb_tx_full(usb_tx_full),
    .usb_rden_l(usb_rden_l), .usb_wren_l(usb_wren_l), .usb_outen_l(usb_outen_l),
    .rx_afull(rx_afull), .rx_wren(rx_wren), .rx_wdata(rx_wdata),
    .tx_empty(tx_empty), .tx_rdata(tx_rdata), .tx_rden(tx_rden)
`ifdef USB_BUS_CTRL_STATS_EN
    , .stat_rx_words(stat_rx_words), .stat_tx_words(stat_tx_words),
    .stat_turnarounds(stat_turnarounds)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] host_rx[$];
  logic [31:0] tx_q[$];
  int          run_len[$];
  bit          run_rx[$];
  int          rx_count = 0, tx_count = 0, wren_low = 0, tx_rden_cnt = 0;
  int          afull_pct = 0, txfull_pct = 0, gap_pct = 0;
  bit          afull_force = 0;
  logic        s_outen, s_rden, s_wren;

  typedef struct {
    int n_rx; int n_tx; int afull_pct; int txfull_pct; int gap_pct;
    int exp_rx; int exp_tx;
  } scen_t;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    usb_rx_empty = (host_rx.size() == 0) || (int'($urandom_range(99)) < gap_pct);
    host_data    = (host_rx.size() != 0) ? host_rx[0] : 32'h0;
    tx_empty     = (tx_q.size() == 0);
    tx_rdata     = tx_empty ? 32'hBAD0_0000 : tx_q[0];
    rx_afull     = afull_force || (int'($urandom_range(99)) < afull_pct);
    usb_tx_full  = int'($urandom_range(99)) < txfull_pct;
  endtask

  task automatic load(input int n_rx, input int n_tx);
    for (int i = 0; i < n_rx; i++) host_rx.push_back($urandom);
    for (int i = 0; i < n_tx; i++) tx_q.push_back($urandom);
    drive_inputs();
  endtask

  // One bus cycle: sample at the falling edge, let the rising edge act, then check and update the host/FIFO model.
  task automatic cycle();
    bit          rd_fire, wr_fire;
    logic [31:0] rd_word;
    @(negedge clk);
    s_outen = usb_outen_l; s_rden = usb_rden_l; s_wren = usb_wren_l;
    rd_fire = !usb_rden_l && !usb_rx_empty;
    wr_fire = !usb_wren_l && !usb_tx_full;
    rd_word = host_data;
    chk(usb_wren_l == !tx_rden, "wren_vs_tx_rden", 32'(usb_wren_l), 32'(!tx_rden));
    chk(usb_outen_l || usb_wren_l, "outen_wren_overlap", 32'(usb_outen_l), 32'd1);
    if (!usb_rden_l) chk(!usb_outen_l, "rden_without_outen", 32'(usb_outen_l), 32'd0);
    if (!usb_wren_l) begin
      chk(!usb_tx_full && !tx_empty, "wren_without_req", {30'b0, usb_tx_full, tx_empty}, 32'd0);
      chk(usb_be == 4'hF, "tx_be", 32'(usb_be), 32'hF);
      wren_low++;
    end
    if (tx_rden) tx_rden_cnt++;
    if (wr_fire && tx_q.size() != 0) chk(usb_data == tx_q[0], "tx_data", usb_data, tx_q[0]);
    if (rd_fire || wr_fire) begin
      if (run_len.size() == 0 || run_rx[run_rx.size()-1] != rd_fire) begin
        run_len.push_back(1);
        run_rx.push_back(rd_fire);
      end else begin
        run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
      end
    end
    @(posedge clk);
    #1;
    chk(rx_wren == rd_fire, "rx_wren", 32'(rx_wren), 32'(rd_fire));
    if (rd_fire) begin
      chk(rx_wdata == rd_word, "rx_wdata", rx_wdata, rd_word);
      if (host_rx.size() != 0) void'(host_rx.pop_front());
    end
    if (rx_wren) rx_count++;
    if (wr_fire && tx_q.size() != 0) begin
      void'(tx_q.pop_front());
      tx_count++;
    end
    drive_inputs();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((host_rx.size() != 0 || tx_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    repeat (4) cycle();
    chk(n < budget, name, 32'(n), 32'(budget));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk(usb_rden_l == 1'b1,  "rst_rden_l",  32'(usb_rden_l),  32'd1);
    chk(usb_wren_l == 1'b1,  "rst_wren_l",  32'(usb_wren_l),  32'd1);
    chk(usb_outen_l == 1'b1, "rst_outen_l", 32'(usb_outen_l), 32'd1);
    chk(rx_wren == 1'b0,     "rst_rx_wren", 32'(rx_wren),     32'd0);
    chk(rx_wdata == 32'd0,   "rst_rx_wdata", rx_wdata,        32'd0);
    chk(tx_rden == 1'b0,     "rst_tx_rden", 32'(tx_rden),     32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    scen_t       tbl[5];
    int          base_rx, base_tx, base_wl, base_tr, ta, n;
    bit          wr_seen;
    int          exp_runs[6] = '{4, 4, 4, 4, 2, 2};

    tbl[0] = '{12, 0,  0,  0,  0, 12, 0};
    tbl[1] = '{0,  9,  0, 40,  0, 0,  9};
    tbl[2] = '{20, 20, 30, 0, 20, 20, 20};
    tbl[3] = '{25, 25, 20, 30, 20, 25, 25};
    tbl[4] = '{7,  30, 0, 50,  0, 7,  30};

    rst = 1'b1;
    drive_inputs();
    do_reset();

    // RX only: one turnaround cycle, then eight words in order, never a write.
    load(8, 0);
    base_rx = rx_count; ta = -1; wr_seen = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!s_wren) wr_seen = 1;
      if (ta < 0 && !s_outen) begin
        ta = i;
        chk(s_rden == 1'b1, "rd_ta_rden_high", 32'(s_rden), 32'd1);
      end else if (ta >= 0 && i == ta + 1) begin
        chk(s_rden == 1'b0, "rd_burst_rden_low", 32'(s_rden), 32'd0);
      end
    end
    chk(ta >= 0, "rd_ta_seen", 32'(ta), 32'd0);
    chk(rx_count - base_rx == 8, "rx_only_total", 32'(rx_count - base_rx), 32'd8);
    chk(!wr_seen, "rx_only_no_write", 32'(wr_seen), 32'd0);

    // TX only: five strobes, five pops.
    load(0, 5);
    base_tx = tx_count; base_wl = wren_low; base_tr = tx_rden_cnt;
    drain("tx_only_drain", 200);
    chk(tx_count - base_tx == 5, "tx_only_total", 32'(tx_count - base_tx), 32'd5);
    chk(wren_low - base_wl == 5, "tx_only_wren_cycles", 32'(wren_low - base_wl), 32'd5);
    chk(tx_rden_cnt - base_tr == 5, "tx_only_pops", 32'(tx_rden_cnt - base_tr), 32'd5);

    // Contention from reset: RX wins first, bursts alternate and are capped at MAX_BURST.
    do_reset();
    run_len.delete(); run_rx.delete();
    base_rx = rx_count; base_tx = tx_count;
    load(10, 10);
    drain("contention_drain", 400);
    chk(run_len.size() == 6, "contention_runs", 32'(run_len.size()), 32'd6);
    for (int i = 0; i < 6 && i < run_len.size(); i++) begin
      chk(run_len[i] == exp_runs[i], "contention_run_len", 32'(run_len[i]), 32'(exp_runs[i]));
      chk(run_rx[i] == (i % 2 == 0), "contention_run_side", 32'(run_rx[i]), 32'(i % 2 == 0));
    end
    chk(rx_count - base_rx == 10, "contention_rx_total", 32'(rx_count - base_rx), 32'd10);
    chk(tx_count - base_tx == 10, "contention_tx_total", 32'(tx_count - base_tx), 32'd10);

    // Back-pressure: rx_afull after three words stops the read strobe one cycle later.
    load(10, 0);
    base_rx = rx_count; n = 0;
    while (rx_count - base_rx < 3 && n < 100) begin cycle(); n++; end
    chk(n < 100, "bp_start", 32'(n), 32'd100);
    afull_force = 1; rx_afull = 1'b1;
    cycle();
    cycle();
    chk(s_rden == 1'b1, "bp_rden_high", 32'(s_rden), 32'd1);
    repeat (4) cycle();
    afull_force = 0;
    drain("bp_drain", 300);
    chk(rx_count - base_rx == 10, "bp_total", 32'(rx_count - base_rx), 32'd10);

    // Scenario table with random gaps, back-pressure and tx_full toggling.
    for (int s = 0; s < 5 + 3; s++) begin
      scen_t sc;
      if (s < 5) sc = tbl[s];
      else begin
        sc.n_rx = int'($urandom_range(40)); sc.n_tx = int'($urandom_range(40));
        sc.afull_pct = int'($urandom_range(40)); sc.txfull_pct = int'($urandom_range(40));
        sc.gap_pct = int'($urandom_range(40)); sc.exp_rx = sc.n_rx; sc.exp_tx = sc.n_tx;
      end
      afull_pct = sc.afull_pct; txfull_pct = sc.txfull_pct; gap_pct = sc.gap_pct;
      base_rx = rx_count; base_tx = tx_count;
      load(sc.n_rx, sc.n_tx);
      drain("scen_drain", 3000);
      afull_pct = 0; txfull_pct = 0; gap_pct = 0;
      repeat (3) cycle();
      chk(rx_count - base_rx == sc.exp_rx, "scen_rx_total", 32'(rx_count - base_rx), 32'(sc.exp_rx));
      chk(tx_count - base_tx == sc.exp_tx, "scen_tx_total", 32'(tx_count - base_tx), 32'(sc.exp_tx));
    end

    // Reset in the middle of a read burst.
    load(20, 0);
    base_rx = rx_count; n = 0;
    while (rx_count - base_rx < 2 && n < 100) begin cycle(); n++; end
    chk(n < 100, "mid_rst_start", 32'(n), 32'd100);
    #2;
    rst = 1'b1;
    #1;
    chk(usb_rden_l == 1'b1,  "mid_rst_rden_l",  32'(usb_rden_l),  32'd1);
    chk(usb_outen_l == 1'b1, "mid_rst_outen_l", 32'(usb_outen_l), 32'd1);
    chk(usb_wren_l == 1'b1,  "mid_rst_wren_l",  32'(usb_wren_l),  32'd1);
    chk(rx_wren == 1'b0,     "mid_rst_rx_wren", 32'(rx_wren),     32'd0);
`ifdef USB_BUS_CTRL_STATS_EN
    chk(stat_rx_words == 32'd0, "mid_rst_stat_rx", stat_rx_words, 32'd0);
    chk(stat_turnarounds == 16'd0, "mid_rst_stat_ta", 32'(stat_turnarounds), 32'd0);
`endif
    cycle();
    cycle();
    chk(rx_wdata == 32'd0, "mid_rst_rx_wdata", rx_wdata, 32'd0);
    rst = 1'b0;
    cycle();
    chk(s_outen == 1'b1, "post_rst_idle", 32'(s_outen), 32'd1);
    cycle();
    chk(!s_outen && s_rden, "post_rst_rd_ta", {30'b0, s_outen, s_rden}, 32'd1);
    drain("post_rst_drain", 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
